// File: rtl/alu_seq_pkg.sv
// Shared types for the arithmetic-unit command sequencer.
// FSM state encoding, function codes and a divide-by-zero helper.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] FUN_ADD = 2'b00;
  localparam logic [1:0] FUN_SUB = 2'b01;
  localparam logic [1:0] FUN_MUL = 2'b10;
  localparam logic [1:0] FUN_DIV = 2'b11;

  function automatic logic is_div_zero(
    input logic [1:0] fun,
    input logic       b_zero
  );
    return (fun == FUN_DIV) && b_zero;
  endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// WAIT-state timeout counter: clear/increment with terminal count.
// tc_o is high once TIMEOUT_CYC-1 increments have accumulated.
module alu_seq_timer #(
  parameter int TIMEOUT_CYC = 8,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Single-op command front-end for the registered arithmetic unit.
// Optional ALU_DIVZERO_CHK_EN: short-circuit div-by-zero to an error response.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int Width       = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [Width-1:0] cmd_a,
  input  logic [Width-1:0] cmd_b,
  input  logic [1:0]       cmd_fun,
  output logic [Width-1:0] ALU_A,
  output logic [Width-1:0] ALU_B,
  output logic [1:0]       ALU_FUN,
  output logic             Arith_Enable,
  input  logic [Width-1:0] Arith_OUT,
  input  logic             Carry_OUT,
  input  logic             Arith_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e           state_q;
  logic [Width-1:0] alu_a_q;
  logic [Width-1:0] alu_b_q;
  logic [1:0]       alu_fun_q;
  logic             en_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [Width-1:0] rsp_data_q;
  logic             rsp_carry_q;
  logic             rsp_err_q;
  logic             tmo_tc;
  logic             divz;

`ifdef ALU_DIVZERO_CHK_EN
  assign divz = is_div_zero(cmd_fun, cmd_b == '0);
`else
  assign divz = 1'b0;
`endif

  alu_seq_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk_i (CLK),
    .rst_ni(RST),
    .clr_i (state_q != WAIT),
    .inc_i (state_q == WAIT && !Arith_Flag),
    .tc_o  (tmo_tc)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      en_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            alu_fun_q   <= cmd_fun;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (divz) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_carry_q <= 1'b0;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // enable stays up through WAIT so the unit's outputs hold
          state_q <= WAIT;
          en_q    <= 1'b1;
        end
        WAIT: begin
          if (Arith_Flag) begin
            state_q     <= RESP;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= Arith_OUT;
            rsp_carry_q <= Carry_OUT & (alu_fun_q == FUN_ADD);
            rsp_err_q   <= 1'b0;
          end else if (tmo_tc) begin
            state_q     <= RESP;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ALU_A        = alu_a_q;
  assign ALU_B        = alu_b_q;
  assign ALU_FUN      = alu_fun_q;
  assign Arith_Enable = en_q;
  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_err      = rsp_err_q;

endmodule
